// File: rtl/iq_readout_seq.sv
// iq_readout_seq: read-side sequencer for the IQ sample buffer.
// On a host command it reloads the buffer read pointer (write pointer plus
// offset), waits out the buffer's read latency, then streams N IQ pairs as
// alternating 16-bit I and Q words over a valid/ready handshake.
module iq_readout_seq #(
    parameter int DEPTH_LOG2 = 13,
    parameter int CNT_W      = DEPTH_LOG2 + 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DEPTH_LOG2-1:0] cmd_offset,
    input  logic [CNT_W-1:0]      cmd_pairs,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      pairs_left,
    output logic                  smp_sync,
    output logic [DEPTH_LOG2-1:0] smp_offset,
    output logic                  smp_sel_i,
    output logic                  smp_adv,
    input  logic [15:0]           smp_data,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SETTLE,
        S_WORD_I,
        S_WORD_Q,
        S_DONE
    } state_t;

    // Longer requests would re-read samples the writer has already overwritten.
    localparam logic [CNT_W-1:0] MAX_PAIRS = CNT_W'(1) << DEPTH_LOG2;

    state_t                  state;
    state_t                  state_next;
    logic [DEPTH_LOG2-1:0]   offset_q;
    logic                    aborted_q;
    logic                    cmd_accept;
    logic                    abort_take;
    logic                    q_accept;

    // State register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers update with non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs; aborts win over handshakes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        aborted    = 1'b0;
        smp_sync   = 1'b0;
        smp_sel_i  = 1'b0;
        smp_adv    = 1'b0;
        out_valid  = 1'b0;
        cmd_accept = 1'b0;
        abort_take = 1'b0;
        q_accept   = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cmd_accept = 1'b1;
                    state_next = (cmd_pairs == '0) ? S_DONE : S_SYNC;
                end
            end
            S_SYNC: begin
                smp_sync = 1'b1;
                if (abort) begin
                    abort_take = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Buffer output is still the stale address; all strobes stay low.
                if (abort) begin
                    abort_take = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_WORD_I;
                end
            end
            S_WORD_I: begin
                smp_sel_i = 1'b1;
                out_valid = 1'b1;
                if (abort) begin
                    abort_take = 1'b1;
                    state_next = S_DONE;
                end else if (out_ready) begin
                    state_next = S_WORD_Q;
                end
            end
            S_WORD_Q: begin
                out_valid = 1'b1;
                if (abort) begin
                    abort_take = 1'b1;
                    state_next = S_DONE;
                end else if (out_ready) begin
                    // Buffer adds rd_q to its address combinationally, so the
                    // next I word is ready on the following cycle.
                    smp_adv    = 1'b1;
                    q_accept   = 1'b1;
                    state_next = (pairs_left == CNT_W'(1)) ? S_DONE : S_WORD_I;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                aborted    = aborted_q;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, pair countdown and abort flag.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            offset_q   <= '0;
            pairs_left <= '0;
            aborted_q  <= 1'b0;
        end else begin
            if (cmd_accept) begin
                offset_q   <= cmd_offset;
                pairs_left <= (cmd_pairs > MAX_PAIRS) ? MAX_PAIRS : cmd_pairs;
            end else if (q_accept) begin
                pairs_left <= pairs_left - CNT_W'(1);
            end

            if (abort_take) begin
                aborted_q <= 1'b1;
            end else if (state == S_DONE) begin
                aborted_q <= 1'b0;
            end
        end
    end

    assign smp_offset = offset_q;
    assign out_data   = smp_data;

endmodule

// File: tb/tb_iq_readout_seq.sv
// Testbench for iq_readout_seq: a behavioural buffer plus a timeline-level
// model of the readout, compared every cycle, and directed command scenarios
// with hand-computed word streams and cycle numbers.
module tb_iq_readout_seq;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        start;
    logic        abort;
    logic [12:0] cmd_offset;
    logic [13:0] cmd_pairs;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [13:0] pairs_left;
    logic        smp_sync;
    logic [12:0] smp_offset;
    logic        smp_sel_i;
    logic        smp_adv;
    logic [15:0] smp_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    iq_readout_seq #(.DEPTH_LOG2(13), .CNT_W(14)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .start      (start),
        .abort      (abort),
        .cmd_offset (cmd_offset),
        .cmd_pairs  (cmd_pairs),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pairs_left (pairs_left),
        .smp_sync   (smp_sync),
        .smp_offset (smp_offset),
        .smp_sel_i  (smp_sel_i),
        .smp_adv    (smp_adv),
        .smp_data   (smp_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer stand-in: address k holds {Q = 0x8000+k, I = k}.
    logic [31:0] mem [8192];
    logic [12:0] wp;
    logic [12:0] buf_addr = '0;

    // Read pointer: reload on sync, step on advance.
    always @(posedge rd_clk) begin
        if (smp_sync)     buf_addr <= wp + smp_offset;
        else if (smp_adv) buf_addr <= buf_addr + 13'd1;
    end

    assign smp_data = smp_sel_i ? mem[buf_addr][15:0] : mem[buf_addr][31:16];

    // Timeline model: cycles since accepted start, expected word queue, pairs owed.
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_abt  = 0;
    int          m_since = 0;
    int          m_left  = 0;
    int          m_widx  = 0;
    logic [12:0] m_off   = '0;
    logic [15:0] m_words[$];

    always @(negedge rd_clk) begin
        bit          streaming;
        int          p;
        logic [12:0] a;
        if (rd_rst) begin
            m_busy = 0; m_done = 0; m_abt = 0; m_since = 0;
            m_left = 0; m_widx = 0; m_off = '0;
            m_words.delete();
            check("rst_busy",       32'(busy),       32'(0));
            check("rst_done",       32'(done),       32'(0));
            check("rst_out_valid",  32'(out_valid),  32'(0));
            check("rst_pairs_left", 32'(pairs_left), 32'(0));
            check("rst_smp_offset", 32'(smp_offset), 32'(0));
        end else begin
            streaming = m_busy && !m_done && (m_since >= 3);
            check("busy",       32'(busy),       32'(m_busy));
            check("done",       32'(done),       32'(m_done));
            check("aborted",    32'(aborted),    32'(m_done && m_abt));
            check("smp_sync",   32'(smp_sync),   32'(m_busy && !m_done && m_since == 1));
            check("out_valid",  32'(out_valid),  32'(streaming));
            check("smp_sel_i",  32'(smp_sel_i),  32'(streaming && (m_widx % 2 == 0)));
            check("smp_adv",    32'(smp_adv),
                  32'(streaming && (m_widx % 2 == 1) && out_ready && !abort));
            check("pairs_left", 32'(pairs_left), 32'(m_left));
            if (m_busy && !m_done && m_since == 1)
                check("smp_offset", 32'(smp_offset), 32'(m_off));
            if (streaming && m_words.size() > 0)
                check("out_data", 32'(out_data), 32'(m_words[0]));

            if (m_done) begin
                m_busy = 0; m_done = 0; m_abt = 0;
            end else if (m_busy) begin
                if (abort) begin
                    m_done = 1; m_abt = 1;
                end else if (streaming && out_ready) begin
                    void'(m_words.pop_front());
                    m_widx++;
                    if (m_widx % 2 == 0) begin
                        m_left--;
                        if (m_left == 0) m_done = 1;
                    end
                end
                m_since++;
            end else if (start) begin
                p = (cmd_pairs > 14'd8192) ? 8192 : int'(cmd_pairs);
                m_busy = 1; m_since = 1; m_left = p; m_abt = 0; m_widx = 0;
                m_off = cmd_offset;
                m_words.delete();
                for (int j = 0; j < p; j++) begin
                    a = wp + cmd_offset + 13'(j);
                    m_words.push_back(16'(a));
                    m_words.push_back(16'h8000 + 16'(a));
                end
                if (p == 0) m_done = 1;
            end
        end
    end

    // Per-command observations taken by the directed driver.
    logic [15:0] obs_words[$];
    logic [15:0] obs_stall[$];
    int          obs_sync[$];
    int          obs_done_cyc;
    int          obs_stall_adv;
    int          obs_adv_abort;
    int          obs_valid_cnt;
    int          obs_left_c1;
    int          obs_left_done;
    logic        obs_aborted;

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // Issue one command at cycle 0 and observe until the cycle after done.
    task automatic run_cmd(input logic [12:0] off, input logic [13:0] np,
                           input int budget = 100, input int stall_at = -1,
                           input int stall_len = 0, input int abort_at = -1,
                           input bit hold_start = 0);
        obs_words.delete(); obs_stall.delete(); obs_sync.delete();
        obs_done_cyc = -1; obs_stall_adv = 0; obs_adv_abort = 0;
        obs_valid_cnt = 0; obs_left_c1 = -1; obs_left_done = -1; obs_aborted = 1'b0;
        cmd_offset = off; cmd_pairs = np; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge rd_clk);
            if (out_valid) obs_valid_cnt++;
            if (smp_sync) obs_sync.push_back(c);
            if (out_valid && !out_ready) begin
                obs_stall.push_back(out_data);
                if (smp_adv) obs_stall_adv++;
            end
            if (abort && smp_adv) obs_adv_abort++;
            if (out_valid && out_ready && !abort) obs_words.push_back(out_data);
            if (c == 1) obs_left_c1 = int'(pairs_left);
            if (done) begin
                obs_done_cyc = c; obs_aborted = aborted; obs_left_done = int'(pairs_left);
            end
            tick();
            out_ready = !(stall_at >= 0 && c + 1 >= stall_at && c + 1 < stall_at + stall_len);
            abort     = (c + 1 == abort_at);
            start     = hold_start && (obs_done_cyc < 0);
            if (hold_start) cmd_pairs = 14'd7;
            if (obs_done_cyc >= 0) break;
        end
        abort = 1'b0; start = 1'b0; out_ready = 1'b1;
        check("cmd_completed", 32'(obs_done_cyc >= 0), 32'(1));
    endtask

    task automatic check_words(input string name, input logic [15:0] exp[$]);
        check({name, "_count"}, 32'(obs_words.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_words.size(); i++)
            check($sformatf("%s[%0d]", name, i), 32'(obs_words[i]), 32'(exp[i]));
    endtask

    logic [15:0] exp_q[$];
    int          dn;

    initial begin
        for (int k = 0; k < 8192; k++) mem[k] = {16'h8000 + 16'(k), 16'(k)};
        rd_rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        cmd_offset = '0; cmd_pairs = '0; wp = 13'd100;

        // Reset state.
        @(negedge rd_clk);
        check("reset_busy",     32'(busy),       32'(0));
        check("reset_done",     32'(done),       32'(0));
        check("reset_aborted",  32'(aborted),    32'(0));
        check("reset_sync",     32'(smp_sync),   32'(0));
        check("reset_sel_i",    32'(smp_sel_i),  32'(0));
        check("reset_adv",      32'(smp_adv),    32'(0));
        check("reset_left",     32'(pairs_left), 32'(0));
        check("reset_offset",   32'(smp_offset), 32'(0));
        tick(); tick();
        rd_rst = 1'b0;
        tick();

        // Basic stream.
        run_cmd(13'd5, 14'd3);
        exp_q = '{16'd105, 16'h8069, 16'd106, 16'h806A, 16'd107, 16'h806B};
        check_words("basic_words", exp_q);
        check("basic_done_cyc",  32'(obs_done_cyc),  32'(9));
        check("basic_sync_cnt",  32'(obs_sync.size()), 32'(1));
        if (obs_sync.size() > 0) check("basic_sync_cyc", 32'(obs_sync[0]), 32'(1));
        check("basic_left_c1",   32'(obs_left_c1),   32'(3));

        // Backpressure on the 2nd word for 4 cycles.
        run_cmd(13'd5, 14'd3, 100, 4, 4);
        check_words("bp_words", exp_q);
        check("bp_done_cyc",    32'(obs_done_cyc),     32'(13));
        check("bp_stall_cnt",   32'(obs_stall.size()), 32'(4));
        foreach (obs_stall[i]) check("bp_stall_data", 32'(obs_stall[i]), 32'(16'h8069));
        check("bp_stall_adv",   32'(obs_stall_adv),    32'(0));

        // Wrap-around.
        wp = 13'd8190;
        run_cmd(13'd0, 14'd4);
        exp_q = '{16'h1FFE, 16'h9FFE, 16'h1FFF, 16'h9FFF, 16'h0000, 16'h8000, 16'h0001, 16'h8001};
        check_words("wrap_words", exp_q);
        check("wrap_done_cyc", 32'(obs_done_cyc), 32'(11));

        // Zero-length command.
        run_cmd(13'd7, 14'd0);
        check("zero_done_cyc",  32'(obs_done_cyc),     32'(1));
        check("zero_valid_cnt", 32'(obs_valid_cnt),    32'(0));
        check("zero_sync_cnt",  32'(obs_sync.size()),  32'(0));
        check("zero_aborted",   32'(obs_aborted),      32'(0));

        // Clamped long request.
        wp = 13'd0;
        run_cmd(13'd0, 14'd9000, 20000);
        check("big_left_c1",    32'(obs_left_c1),       32'(8192));
        check("big_word_cnt",   32'(obs_words.size()),  32'(16384));
        if (obs_words.size() == 16384)
            check("big_last_word", 32'(obs_words[16383]), 32'(16'h9FFF));
        check("big_done_cyc",   32'(obs_done_cyc),      32'(16387));

        // Abort on the 3rd accept (an I word), then restart right away.
        wp = 13'd100;
        run_cmd(13'd5, 14'd10, 100, -1, 0, 5);
        exp_q = '{16'd105, 16'h8069};
        check_words("abort_words", exp_q);
        check("abort_done_cyc", 32'(obs_done_cyc),  32'(6));
        check("abort_flag",     32'(obs_aborted),   32'(1));
        check("abort_left",     32'(obs_left_done), 32'(9));
        check("abort_adv",      32'(obs_adv_abort), 32'(0));
        run_cmd(13'd0, 14'd1);
        exp_q = '{16'd100, 16'h8064};
        check_words("restart_words", exp_q);
        check("restart_done_cyc", 32'(obs_done_cyc), 32'(5));
        check("restart_aborted",  32'(obs_aborted),  32'(0));

        // Abort coincident with a Q accept: no advance, count frozen.
        run_cmd(13'd5, 14'd10, 100, -1, 0, 4);
        check("abortq_adv",      32'(obs_adv_abort), 32'(0));
        check("abortq_left",     32'(obs_left_done), 32'(10));
        check("abortq_done_cyc", 32'(obs_done_cyc),  32'(5));
        check("abortq_flag",     32'(obs_aborted),   32'(1));

        // Start held high (with a different count) while busy is ignored.
        run_cmd(13'd5, 14'd2, 100, -1, 0, -1, 1);
        exp_q = '{16'd105, 16'h8069, 16'd106, 16'h806A};
        check_words("hold_words", exp_q);
        check("hold_done_cyc", 32'(obs_done_cyc), 32'(7));

        // Asynchronous reset in the middle of a Q word.
        cmd_offset = 13'd3; cmd_pairs = 14'd5; start = 1'b1; out_ready = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b0;
        check("pre_rst_in_q", 32'(out_valid && !smp_sel_i), 32'(1));
        #2 rd_rst = 1'b1;
        #1;
        check("arst_busy",      32'(busy),       32'(0));
        check("arst_valid",     32'(out_valid),  32'(0));
        check("arst_sel_i",     32'(smp_sel_i),  32'(0));
        check("arst_adv",       32'(smp_adv),    32'(0));
        check("arst_done",      32'(done),       32'(0));
        check("arst_left",      32'(pairs_left), 32'(0));
        check("arst_offset",    32'(smp_offset), 32'(0));
        tick();
        rd_rst = 1'b0; out_ready = 1'b1;
        dn = 0;
        repeat (5) begin
            @(negedge rd_clk);
            if (done || busy) dn++;
        end
        check("arst_no_done", 32'(dn), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
